// File: rtl/int_arbiter_ctrl.sv
// int_arbiter_ctrl: memory-mapped fixed-priority interrupt controller with req/ack/done handshake
// Ports: i_clk/i_rst (sync active-high); i_memAddr/i_memDataIn/i_memWrEn/o_memDataOut register window
// (00 MASK, 01 PEND w1c, 10 CTRL, 11 SWTRIG); i_intSrc raw sources; o_intReq/o_intVec/i_intAck/i_intDone core handshake.
// Optional macro ICTRL_ACK_TIMEOUT_EN: abandons an unacknowledged request after 255 cycles and flags CTRL.TIMEOUT.
module int_arbiter_ctrl #(
  parameter int NUM_SRC = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [1:0]         i_memAddr,
  input  logic [15:0]        i_memDataIn,
  input  logic               i_memWrEn,
  output logic [15:0]        o_memDataOut,
  input  logic [NUM_SRC-1:0] i_intSrc,
  output logic               o_intReq,
  output logic [3:0]         o_intVec,
  input  logic               i_intAck,
  input  logic               i_intDone
);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, SVC = 2'd2;
  logic [1:0] state, nextState;
  logic [NUM_SRC-1:0] srcQ, srcEdge, pend, mask, elig, w1c, swSet, ackClr, vecSel;
  logic gie, timeout, toHit, activeOk, wrMask, wrPend, wrCtrl, wrSw;
  logic [3:0] win;
  assign wrMask = i_memWrEn && i_memAddr == 2'd0;
  assign wrPend = i_memWrEn && i_memAddr == 2'd1;
  assign wrCtrl = i_memWrEn && i_memAddr == 2'd2;
  assign wrSw = i_memWrEn && i_memAddr == 2'd3;
  assign srcEdge = i_intSrc & ~srcQ;
  assign w1c = wrPend ? i_memDataIn[NUM_SRC-1:0] : '0;
  assign swSet = wrSw ? i_memDataIn[NUM_SRC-1:0] : '0;
  // one-hot of the locked vector; a shift avoids out-of-range part selects on o_intVec
  assign vecSel = NUM_SRC'(1) << o_intVec;
  assign ackClr = (state == REQ && i_intAck) ? vecSel : '0;
  assign activeOk = |(pend & mask & vecSel);
  assign elig = gie ? (pend & mask) : '0;
  always_comb begin
    win = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) win = elig[i] ? 4'(i) : win;
  end
  // sets are ORed in after clears so a new edge or software trigger always wins
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      srcQ <= '0;
      pend <= '0;
      mask <= '0;
      gie <= 1'b0;
    end else begin
      srcQ <= i_intSrc;
      pend <= (pend & ~w1c & ~ackClr) | srcEdge | swSet;
      mask <= wrMask ? i_memDataIn[NUM_SRC-1:0] : mask;
      gie <= wrCtrl ? i_memDataIn[0] : gie;
    end
  end
`ifdef ICTRL_ACK_TIMEOUT_EN
  logic [7:0] ackCnt;
  // counter is zero on the first REQ cycle, so 254 marks the 255th cycle without ack
  assign toHit = state == REQ && !i_intAck && ackCnt == 8'd254;
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ackCnt <= '0;
      timeout <= 1'b0;
    end else begin
      ackCnt <= (state == REQ) ? ackCnt + 8'd1 : 8'd0;
      timeout <= toHit | (timeout & ~(wrCtrl & i_memDataIn[3]));
    end
  end
`else
  assign toHit = 1'b0;
  assign timeout = 1'b0;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else state <= nextState;
  end
  // FSM sees register values from before any same-cycle write
  always_comb begin
    nextState = state == IDLE ? (|elig ? REQ : IDLE) :
                state == REQ  ? (i_intAck ? SVC : (!gie || !activeOk || toHit) ? IDLE : REQ) :
                state == SVC  ? (i_intDone ? IDLE : SVC) : IDLE;
  end
  always_comb begin
    o_intReq = state == REQ;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) o_intVec <= '0;
    else if (state == IDLE && |elig) o_intVec <= win;
  end
  always_comb begin
    o_memDataOut = i_memAddr == 2'd0 ? {{(16-NUM_SRC){1'b0}}, mask} :
                   i_memAddr == 2'd1 ? {{(16-NUM_SRC){1'b0}}, pend} :
                   i_memAddr == 2'd2 ? {8'd0, o_intVec, timeout, state, gie} : 16'd0;
  end
endmodule

// File: tb/tb_int_arbiter_ctrl.sv
// tb_int_arbiter_ctrl: scenario tasks with a queue of expected values for int_arbiter_ctrl
module tb_int_arbiter_ctrl;
  logic i_clk = 0, i_rst = 0, i_memWrEn = 0, i_intAck = 0, i_intDone = 0;
  logic [1:0] i_memAddr = 0;
  logic [15:0] i_memDataIn = 0, o_memDataOut;
  logic [3:0] i_intSrc = 0, o_intVec;
  logic o_intReq;
  logic [15:0] expQ[$];
  logic [15:0] obs, want;
  int total = 0, bad = 0;

  int_arbiter_ctrl #(.NUM_SRC(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_memAddr(i_memAddr), .i_memDataIn(i_memDataIn),
    .i_memWrEn(i_memWrEn), .o_memDataOut(o_memDataOut), .i_intSrc(i_intSrc),
    .o_intReq(o_intReq), .o_intVec(o_intVec), .i_intAck(i_intAck), .i_intDone(i_intDone)
  );

  always #5 i_clk = ~i_clk;

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [15:0] d);
    i_memAddr = a; i_memDataIn = d; i_memWrEn = 1;
    step;
    i_memWrEn = 0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [15:0] d);
    i_memAddr = a;
    #1;
    d = o_memDataOut;
  endtask

  task automatic test_reset;
    i_rst = 1; step; step; i_rst = 0;
    expQ.push_back(16'h0); obs = {15'd0, o_intReq}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL reset_req got=%h want=%h", obs, want); end
    expQ.push_back(16'h0); obs = {12'd0, o_intVec}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL reset_vec got=%h want=%h", obs, want); end
    for (int a = 0; a < 4; a++) begin
      expQ.push_back(16'h0); rd(2'(a), obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL reset_reg%0d got=%h want=%h", a, obs, want); end
    end
  endtask

  task automatic test_basic;
    wr(2, 16'h1); wr(0, 16'h3);
    i_intSrc = 4'h2;
    expQ.push_back(16'h2); expQ.push_back(16'h0); step;
    rd(1, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL basic_pend got=%h want=%h", obs, want); end
    obs = {15'd0, o_intReq}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL basic_req_lat got=%h want=%h", obs, want); end
    expQ.push_back(16'h13); step;
    rd(2, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL basic_ctrl_req got=%h want=%h", obs, want); end
    total++; if (o_intReq !== 1'b1) begin bad++; $display("FAIL basic_req got=%b want=1", o_intReq); end
    i_intSrc = 0; i_intAck = 1;
    expQ.push_back(16'h0); expQ.push_back(16'h15); step; i_intAck = 0;
    rd(1, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL basic_ack_pend got=%h want=%h", obs, want); end
    rd(2, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL basic_svc got=%h want=%h", obs, want); end
    i_intDone = 1;
    expQ.push_back(16'h11); step; i_intDone = 0;
    rd(2, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL basic_done got=%h want=%h", obs, want); end
  endtask

  task automatic test_priority;
    wr(0, 16'hF);
    i_intSrc = 4'h5; step; i_intSrc = 0;
    expQ.push_back(16'h10); step;
    obs = {11'd0, o_intReq, o_intVec}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL prio_first got=%h want=%h", obs, want); end
    i_intAck = 1;
    expQ.push_back(16'h4); expQ.push_back(16'h05); step; i_intAck = 0;
    rd(1, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL prio_pend got=%h want=%h", obs, want); end
    rd(2, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL prio_svc got=%h want=%h", obs, want); end
    i_intDone = 1;
    expQ.push_back(16'h0); step; i_intDone = 0;
    obs = {15'd0, o_intReq}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL prio_idle got=%h want=%h", obs, want); end
    expQ.push_back(16'h12); step;
    obs = {11'd0, o_intReq, o_intVec}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL prio_second got=%h want=%h", obs, want); end
  endtask

  task automatic test_no_preempt;
    i_intSrc = 4'h1;
    expQ.push_back(16'h5); expQ.push_back(16'h12); step; i_intSrc = 0;
    rd(1, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL nopre_pend got=%h want=%h", obs, want); end
    obs = {11'd0, o_intReq, o_intVec}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL nopre_vec1 got=%h want=%h", obs, want); end
    expQ.push_back(16'h12); step;
    obs = {11'd0, o_intReq, o_intVec}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL nopre_vec2 got=%h want=%h", obs, want); end
    i_intAck = 1;
    expQ.push_back(16'h1); step; i_intAck = 0;
    rd(1, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL nopre_ack got=%h want=%h", obs, want); end
    i_intDone = 1; step; i_intDone = 0;
    expQ.push_back(16'h10); step;
    obs = {11'd0, o_intReq, o_intVec}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL nopre_next got=%h want=%h", obs, want); end
    i_intAck = 1; step; i_intAck = 0;
    i_intDone = 1;
    expQ.push_back(16'h0); step; i_intDone = 0;
    rd(1, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL nopre_clear got=%h want=%h", obs, want); end
  endtask

  task automatic test_w1c_withdraw;
    wr(3, 16'h4);
    expQ.push_back(16'h12); step;
    obs = {11'd0, o_intReq, o_intVec}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL w1c_req got=%h want=%h", obs, want); end
    expQ.push_back(16'h0); expQ.push_back(16'h1); wr(1, 16'h4);
    rd(1, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL w1c_pend got=%h want=%h", obs, want); end
    obs = {15'd0, o_intReq}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL w1c_prewrite got=%h want=%h", obs, want); end
    expQ.push_back(16'h21); step;
    rd(2, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL w1c_withdraw got=%h want=%h", obs, want); end
    wr(3, 16'h4); step;
    i_memAddr = 1; i_memDataIn = 16'h4; i_memWrEn = 1; i_intAck = 1;
    expQ.push_back(16'h25); expQ.push_back(16'h0); step; i_memWrEn = 0; i_intAck = 0;
    rd(2, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL w1c_ack_svc got=%h want=%h", obs, want); end
    rd(1, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL w1c_ack_pend got=%h want=%h", obs, want); end
    i_intDone = 1; step; i_intDone = 0;
  endtask

  task automatic test_gie_sw_reset;
    wr(2, 16'h0); wr(3, 16'h8);
    expQ.push_back(16'h8); expQ.push_back(16'h0); step;
    rd(1, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL gie_pend got=%h want=%h", obs, want); end
    obs = {15'd0, o_intReq}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL gie_off got=%h want=%h", obs, want); end
    expQ.push_back(16'h0); wr(2, 16'h1);
    obs = {15'd0, o_intReq}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL gie_prewrite got=%h want=%h", obs, want); end
    expQ.push_back(16'h13); step;
    obs = {11'd0, o_intReq, o_intVec}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL gie_on got=%h want=%h", obs, want); end
    i_rst = 1;
    expQ.push_back(16'h0); expQ.push_back(16'h0); expQ.push_back(16'h0); step; i_rst = 0;
    obs = {11'd0, o_intReq, o_intVec}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL rst_req got=%h want=%h", obs, want); end
    rd(1, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL rst_pend got=%h want=%h", obs, want); end
    rd(2, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL rst_ctrl got=%h want=%h", obs, want); end
  endtask

  task automatic test_timeout;
    int n;
    wr(2, 16'h1); wr(0, 16'hF); wr(3, 16'h2); step;
    n = 0;
    while (o_intReq && n < 400) begin step; n++; end
`ifdef ICTRL_ACK_TIMEOUT_EN
    expQ.push_back(16'd255); expQ.push_back(16'h19); expQ.push_back(16'h11);
    obs = 16'(n); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL to_cycles got=%0d want=%0d", obs, want); end
    rd(2, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL to_flag got=%h want=%h", obs, want); end
    step;
    obs = {11'd0, o_intReq, o_intVec}; want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL to_reissue got=%h want=%h", obs, want); end
`else
    expQ.push_back(16'd400); expQ.push_back(16'h13);
    obs = 16'(n); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL nto_hold got=%0d want=%0d", obs, want); end
    rd(2, obs); want = expQ.pop_front(); total++; if (obs !== want) begin bad++; $display("FAIL nto_ctrl got=%h want=%h", obs, want); end
`endif
  endtask

  initial begin
    test_reset;
    test_basic;
    test_priority;
    test_no_preempt;
    test_w1c_withdraw;
    test_gie_sw_reset;
    test_timeout;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_arbiter_ctrl.md
Name: int_arbiter_ctrl

Overview:
- Memory-mapped interrupt controller. Latches rising edges from NUM_SRC interrupt sources, including the stack-overflow interrupt from the core controller.
- Selects one pending, enabled source by fixed priority and presents it to the core with a request/acknowledge/done handshake.
- Occupies a 4-word window in the memory-mapped block region, beside the core control block.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..15); index 0 is highest priority.

Ports:
- i_clk  in  1  system clock; all state updates on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_memAddr  in  2  register select within window
- i_memDataIn  in  16  write data
- i_memWrEn  in  1  write strobe, one cycle per write
- o_memDataOut  out  16  read data, combinational from i_memAddr
- i_intSrc  in  NUM_SRC  raw interrupt sources; rising edge sets pending
- o_intReq  out  1  interrupt request to core
- o_intVec  out  4  vector (source index) of current request or service
- i_intAck  in  1  core accepts request; one-cycle pulse
- i_intDone  in  1  core finished ISR (return-from-interrupt); one-cycle pulse

Behaviour:
Registers (bits above NUM_SRC-1 read 0, writes ignored):
- 00 MASK: rw enable per source; reset 0.
- 01 PEND: read pending bits; write-1-to-clear.
- 10 CTRL: bit0 GIE (rw, reset 0); bits2:1 FSM state (ro); bit3 TIMEOUT (sticky, write-1-clears; only with optional feature, else reads 0); bits7:4 o_intVec (ro); others 0.
- 11 SWTRIG: write ORs data into PEND; reads 0.

Edge detect and pending:
- i_intSrc registered once (srcQ, reset 0); edge = i_intSrc & ~srcQ.
- PEND next = (PEND & ~W1C) | edge | SWTRIG. Set beats clear on the same bit in the same cycle.
- Latency: source rises in cycle N → PEND set after edge N → o_intReq high after edge N+1, when IDLE, GIE=1 and masked.

Eligibility: elig = PEND & MASK, qualified by GIE; winner = lowest set index.

FSM states (encoding for CTRL[2:1]):
- IDLE (00): o_intReq=0; o_intVec holds last value. If elig≠0, latch winner into o_intVec and go to REQ.
- REQ (01): o_intReq=1 and o_intVec locked (no preemption by higher priority).
  - i_intAck=1: clear PEND[o_intVec] (a same-cycle new edge on that bit re-sets it) and go to SVC.
  - Else, if GIE=0 or PEND[o_intVec]&MASK[o_intVec]=0: withdraw to IDLE. Ack has precedence over withdrawal in the same cycle.
- SVC (10): o_intReq=0; o_intVec holds the serviced index. New edges latch into PEND. i_intDone=1 → IDLE, and a new request may issue the following cycle. GIE changes do not abort SVC.
- i_intAck outside REQ and i_intDone outside SVC are ignored.

Reset: state IDLE; o_intReq=0, o_intVec=0, o_memDataOut reflects reset registers; PEND, MASK, GIE, srcQ, TIMEOUT all 0. Reset asserted mid-REQ or mid-SVC drops o_intReq on the next edge and discards all pending bits.

Register writes: a write in the same cycle as an FSM transition is applied first, and the FSM evaluates using the pre-write values.

Optional Feature:
- Macro ICTRL_ACK_TIMEOUT_EN.
- Defined: 8-bit counter clears on entry to REQ and increments each REQ cycle without ack. If it reaches 255 with no ack: set CTRL.TIMEOUT, return to IDLE, keep PEND bit. The request re-issues after one IDLE cycle.
- Undefined: no counter; REQ waits indefinitely; CTRL bit3 reads 0.

Test Plan:
- Reset, GIE=1, MASK=0x3, pulse i_intSrc[1] at cycle 10 → PEND=0x2 after edge 10, o_intReq=1 and o_intVec=1 after edge 11. Ack → PEND=0x0, state=SVC. Done → IDLE.
- Sources 2 and 0 rise together, MASK=0xF → vector 0 served first. After done, vector 2 is requested the next cycle.
- In REQ for vector 2, raise source 0 → o_intVec stays 2 until ack. Vector 0 is requested after done.
- In REQ, write PEND=0x4 (W1C of active bit) → o_intReq drops next cycle and state returns to IDLE. The same test with i_intAck in the same cycle → SVC.
- Write SWTRIG=0x8, GIE=0 → no request. Set GIE=1 → o_intReq=1, o_intVec=3. Assert i_rst in REQ → o_intReq=0 and PEND=0 next cycle.
- (ICTRL_ACK_TIMEOUT_EN) Request with no ack for 255 cycles → CTRL bit3=1, IDLE for one cycle, request re-asserted with same vector.
